// File: rtl/uart_pkg.sv
// Shared UART baud-rate constants: default field widths, reset divisor and
// the smallest divisor the generator will accept.
package uart_pkg;

  localparam int UART_DIV_W        = 16;
  localparam int UART_FRAC_W       = 4;
  localparam int UART_DEFAULT_DIV  = 651;
  localparam int UART_DEFAULT_FRAC = 1;
  localparam int MIN_DIV           = 2;

endpackage

// File: rtl/baud_frac_ctr.sv
// Single-channel fractional tick counter: emits a one-clock tick every
// div_int (+1 when the fractional accumulator overflows) active cycles.
module baud_frac_ctr
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              active,
  input  logic              resync,
  output logic              tick
);

  logic [DIV_W-1:0]  count;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [DIV_W:0]    cur_len;
  logic [FRAC_W:0]   acc_sum;
  logic              terminal;

  // Only the carry is stored; the period length is rebuilt from the live
  // divisor so a divisor loaded just before activation takes effect at once.
  always_comb begin
    cur_len  = {1'b0, div_int} + {{DIV_W{1'b0}}, carry};
    terminal = ({1'b0, count} == (cur_len - (DIV_W+1)'(1)));
    acc_sum  = {1'b0, acc} + {1'b0, div_frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      carry <= 1'b0;
      tick  <= 1'b0;
    end else if (!active || resync) begin
      count <= '0;
      acc   <= '0;
      carry <= 1'b0;
      tick  <= 1'b0;
    end else if (terminal) begin
      count <= '0;
      acc   <= acc_sum[FRAC_W-1:0];
      carry <= acc_sum[FRAC_W];
      tick  <= 1'b1;
    end else begin
      count <= count + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: independent RX/TX oversample ticks from one
// handshake-loaded divisor, plus RX phase resync and a TX bit-boundary tick.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W        = UART_DIV_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int OSR          = 16,
  parameter int DEFAULT_DIV  = UART_DEFAULT_DIV,
  parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              rx_active,
  input  logic              tx_active,
  input  logic              rx_resync,
  output logic              baud_en_rx,
  output logic              baud_en_tx,
  output logic              tx_bit_tick
);

  localparam int BIT_W = (OSR > 2) ? $clog2(OSR) : 1;

  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [BIT_W-1:0]  bitcnt;
  logic              cfg_accept;
  logic              div_legal;

  always_comb begin
    cfg_ready  = !rx_active && !tx_active;
    cfg_accept = cfg_valid && cfg_ready;
    div_legal  = (cfg_div_int >= DIV_W'(MIN_DIV));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int  <= DIV_W'(DEFAULT_DIV);
      div_frac <= FRAC_W'(DEFAULT_FRAC);
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_accept && !div_legal;
      if (cfg_accept && div_legal) begin
        div_int  <= cfg_div_int;
        div_frac <= cfg_div_frac;
      end
    end
  end

  baud_frac_ctr #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_int  (div_int),
    .div_frac (div_frac),
    .active   (rx_active),
    .resync   (rx_resync),
    .tick     (baud_en_rx)
  );

  baud_frac_ctr #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_int  (div_int),
    .div_frac (div_frac),
    .active   (tx_active),
    .resync   (1'b0),
    .tick     (baud_en_tx)
  );

  // bitcnt counts completed TX ticks; the bit tick is the registered TX tick
  // qualified by the count, so it rides exactly on the OSR-th pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
    end else if (!tx_active) begin
      bitcnt <= '0;
    end else if (baud_en_tx) begin
      bitcnt <= (bitcnt == BIT_W'(OSR-1)) ? '0 : bitcnt + BIT_W'(1);
    end
  end

  always_comb begin
    tx_bit_tick = baud_en_tx && (bitcnt == BIT_W'(OSR-1));
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: expected tick edges are computed from
// the closed-form fractional period formula and checked by a negedge monitor.
module tb_baud_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIV_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_err;
  logic              rx_active;
  logic              tx_active;
  logic              rx_resync;
  logic              baud_en_rx;
  logic              baud_en_tx;
  logic              tx_bit_tick;

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR),
    .DEFAULT_DIV(651), .DEFAULT_FRAC(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .rx_active    (rx_active),
    .tx_active    (tx_active),
    .rx_resync    (rx_resync),
    .baud_en_rx   (baud_en_rx),
    .baud_en_tx   (baud_en_tx),
    .tx_bit_tick  (tx_bit_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int rx_q[$];
  int tx_q[$];
  int bit_q[$];
  int err_q[$];
  int rx_seen[$];
  int m_div  = 651;
  int m_frac = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input string name, input logic out, inout int q[$]);
    while (q.size() > 0 && q[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL %s missed: expected pulse at edge %0d, still absent at edge %0d", name, q[0], cyc);
      void'(q.pop_front());
    end
    if (out === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s unexpected: pulse at edge %0d, expected none", name, cyc);
      end else begin
        chk({name, "_edge"}, cyc, q.pop_front());
      end
    end else if (out !== 1'b0) begin
      chk({name, "_known"}, {31'd0, out}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon("baud_en_rx", baud_en_rx, rx_q);
    mon("baud_en_tx", baud_en_tx, tx_q);
    mon("tx_bit_tick", tx_bit_tick, bit_q);
    mon("cfg_err", cfg_err, err_q);
    if (baud_en_rx === 1'b1) rx_seen.push_back(cyc);
  end

  // Tick k after activation (first active edge a) lands on edge
  // a-1 + k*d + floor((k-1)*f / 2^FRAC_W); only edges <= last are emitted.
  function automatic void push_ticks(input int a, input int last, input int d,
                                     input int f, input bit is_tx);
    int e;
    for (int k = 1; k < 100000; k++) begin
      e = a - 1 + k * d + (((k - 1) * f) >> FRAC_W);
      if (e > last) break;
      if (is_tx) begin
        tx_q.push_back(e);
        if (k % OSR == 0) bit_q.push_back(e);
      end else begin
        rx_q.push_back(e);
      end
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int di, input int fr);
    bit rdy;
    rdy = !rx_active && !tx_active;
    cfg_div_int  = DIV_W'(di);
    cfg_div_frac = FRAC_W'(fr);
    cfg_valid    = 1'b1;
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
    if (rdy) begin
      if (di >= 2) begin
        m_div  = di;
        m_frac = fr;
      end else begin
        err_q.push_back(cyc + 1);
      end
    end
    step(1);
    cfg_valid = 1'b0;
  endtask

  // Activate the chosen channels for len edges; resync pulse at offset r.
  task automatic run_seg(input bit use_rx, input bit use_tx, input int len, input int r);
    int c0;
    int last;
    c0   = cyc;
    last = c0 + len;
    rx_active = use_rx;
    tx_active = use_tx;
    if (use_rx) begin
      if (r >= 0 && r < len) begin
        push_ticks(c0 + 1, c0 + r, m_div, m_frac, 1'b0);
        push_ticks(c0 + r + 2, last, m_div, m_frac, 1'b0);
      end else begin
        push_ticks(c0 + 1, last, m_div, m_frac, 1'b0);
      end
    end
    if (use_tx) push_ticks(c0 + 1, last, m_div, m_frac, 1'b1);
    for (int i = 0; i < len; i++) begin
      rx_resync = (i == r);
      step(1);
    end
    rx_resync = 1'b0;
    rx_active = 1'b0;
    tx_active = 1'b0;
    step(3);
  endtask

  initial begin
    int c0;
    int di;
    int len;
    rst_n        = 1'b0;
    cfg_div_int  = '0;
    cfg_div_frac = '0;
    cfg_valid    = 1'b0;
    rx_active    = 1'b0;
    tx_active    = 1'b0;
    rx_resync    = 1'b0;
    step(3);
    chk("rst_baud_en_rx", {31'd0, baud_en_rx}, 32'd0);
    chk("rst_baud_en_tx", {31'd0, baud_en_tx}, 32'd0);
    chk("rst_tx_bit_tick", {31'd0, tx_bit_tick}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    step(2);

    rx_seen.delete();
    c0 = cyc;
    run_seg(1'b1, 1'b0, 11100, -1);
    if (rx_seen.size() >= 17) begin
      chk("rx_first_latency", rx_seen[0] - c0, 651);
      chk("rx_16tick_interval", rx_seen[16] - rx_seen[0], 10417);
    end else begin
      chk("rx_tick_count", rx_seen.size(), 17);
    end

    do_cfg(4, 0);
    run_seg(1'b0, 1'b1, 200, -1);

    do_cfg(4, 8);
    run_seg(1'b1, 1'b0, 60, -1);

    do_cfg(1, 5);
    step(2);
    c0 = cyc;
    tx_active = 1'b1;
    push_ticks(c0 + 1, c0 + 1, m_div, m_frac, 1'b1);
    do_cfg(3, 2);
    tx_active = 1'b0;
    step(3);
    run_seg(1'b1, 1'b0, 40, -1);

    do_cfg(8, 0);
    run_seg(1'b1, 1'b0, 40, 7);

    do_cfg(5, 3);
    c0 = cyc;
    rx_active = 1'b1;
    tx_active = 1'b1;
    step(5);
    chk("pre_reset_rx_tick", {31'd0, baud_en_rx}, 32'd1);
    chk("pre_reset_tx_tick", {31'd0, baud_en_tx}, 32'd1);
    #1;
    rst_n = 1'b0;
    rx_q.delete();
    tx_q.delete();
    bit_q.delete();
    err_q.delete();
    #1;
    chk("async_rst_rx", {31'd0, baud_en_rx}, 32'd0);
    chk("async_rst_tx", {31'd0, baud_en_tx}, 32'd0);
    chk("async_rst_bit", {31'd0, tx_bit_tick}, 32'd0);
    rx_active = 1'b0;
    tx_active = 1'b0;
    m_div  = 651;
    m_frac = 1;
    step(2);
    rst_n = 1'b1;
    step(2);
    run_seg(1'b1, 1'b1, 700, -1);

    repeat (25) begin
      di  = ($urandom_range(0, 99) < 12) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
      do_cfg(di, int'($urandom_range(0, 15)));
      len = int'($urandom_range(30, 250));
      run_seg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1);
    end

    step(5);
    chk("rx_q_drained", rx_q.size(), 0);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("bit_q_drained", bit_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
